// File: rtl/vec_mac_arbiter.sv
// vec_mac_arbiter: shares one vector MAC between NREQ requesters.
// Round-robin grants of one whole vector (BEATS beats) per grant; a tag FIFO
// remembers the owner of every in-flight vector so MAC results, which return
// in order, are routed back as a 1-cycle strobe to the right requester.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     per-requester beat handshake (ready is one-hot or zero)
//   req_a, req_b        packed beats, requester i at [i*BUSW +: BUSW]
//   resp_valid/sum      one-hot result strobe and its 32-bit sum
//   mac_vec_*           registered beat stream to the MAC
//   mac_result_*        result from the MAC
//   err_orphan          sticky: MAC result with no vector in flight
//
// Optional build macro VMARB_PERF_EN adds perf_busy (cycles with
// mac_vec_valid high) and perf_vecs (16-bit per-requester response counts),
// both saturating.
module vec_mac_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned ELEMS        = 1000,
    parameter int unsigned ACTIVE_LANES = 8,
    parameter int unsigned BUSW         = 128,
    parameter int unsigned TAGD         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BUSW-1:0] req_a,
    input  logic [NREQ*BUSW-1:0] req_b,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_sum,
    output logic                 mac_vec_valid,
    output logic [BUSW-1:0]      mac_vec_a,
    output logic [BUSW-1:0]      mac_vec_b,
    input  logic                 mac_result_valid,
    input  logic [31:0]          mac_result_sum,
    output logic                 err_orphan
`ifdef VMARB_PERF_EN
    ,
    output logic [31:0]          perf_busy,
    output logic [NREQ*16-1:0]   perf_vecs
`endif
);

    localparam int unsigned BEATS = (ELEMS + ACTIVE_LANES - 1) / ACTIVE_LANES;
    localparam int unsigned IW    = $clog2(NREQ);
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = $clog2(TAGD);
    localparam int unsigned CW    = $clog2(TAGD + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   win;
    logic            found;
    logic [BW-1:0]   beat_cnt;
    logic [IW-1:0]   tag_mem [TAGD];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   tag_cnt;
    logic            grant, accept, last_beat, pop, orphan;
    logic [BUSW-1:0] a_arr [NREQ];
    logic [BUSW-1:0] b_arr [NREQ];

    // (base + off) mod NREQ for base, off < NREQ
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Unpack requester buses
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*BUSW +: BUSW];
        assign b_arr[g] = req_b[g*BUSW +: BUSW];
    end

    // Round-robin search starting at rr_ptr
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_valid[wrap_add(rr_ptr, k)]) begin
                found = 1'b1;
                win   = wrap_add(rr_ptr, k);
            end
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        last_beat = 1'b0;
        accept    = (state == STREAM) && req_valid[owner] && req_ready[owner];
        unique case (state)
            IDLE: begin
                if (found && (tag_cnt != CW'(TAGD))) begin
                    grant    = 1'b1;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (accept && (beat_cnt == BW'(BEATS - 1))) begin
                    last_beat = 1'b1;
                    state_nx  = GAP;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign pop    = mac_result_valid && (tag_cnt != '0);
    assign orphan = mac_result_valid && (tag_cnt == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Tag storage; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (grant) tag_mem[wr_ptr] <= win;
    end

    // Grant bookkeeping, beat forwarding, tag FIFO and response path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            owner         <= '0;
            req_ready     <= '0;
            beat_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tag_cnt       <= '0;
            mac_vec_valid <= 1'b0;
            mac_vec_a     <= '0;
            mac_vec_b     <= '0;
            resp_valid    <= '0;
            resp_sum      <= '0;
            err_orphan    <= 1'b0;
        end else begin
            if (grant) begin
                rr_ptr    <= wrap_add(win, 1);
                owner     <= win;
                req_ready <= NREQ'(1) << win;
                wr_ptr    <= wr_ptr + 1'b1;
            end
            if (last_beat) req_ready <= '0;

            mac_vec_valid <= accept;
            if (accept) begin
                beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
                mac_vec_a <= a_arr[owner];
                mac_vec_b <= b_arr[owner];
            end

            tag_cnt <= tag_cnt + CW'(grant) - CW'(pop);

            resp_valid <= '0;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                resp_valid <= NREQ'(1) << tag_mem[rd_ptr];
                resp_sum   <= mac_result_sum;
            end

            if (orphan) err_orphan <= 1'b1;
        end
    end

`ifdef VMARB_PERF_EN
    // Saturating busy-cycle and per-requester response counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy <= '0;
            perf_vecs <= '0;
        end else begin
            if (mac_vec_valid && (perf_busy != '1)) perf_busy <= perf_busy + 32'd1;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (resp_valid[i] && (perf_vecs[i*16 +: 16] != 16'hFFFF))
                    perf_vecs[i*16 +: 16] <= perf_vecs[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule
